prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and
// the byte-index width derived from the instruction word size.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int DEFAULT_STEP = 4;

    // Bits needed to count bytes within one word (at least one bit).
    function automatic int idx_width(input int step);
        return (step > 1) ? $clog2(step) : 1;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams bytes from a byte source into program memory words,
// halting the core while the memory is being rewritten.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 20,
    parameter int STEP             = DEFAULT_STEP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [INSTR_ADDR_WIDTH-1:0] base_addr,
    input  logic [INSTR_ADDR_WIDTH:0]   word_count,
    input  logic                        abort,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    output logic                        byte_ready,
    output logic                        pgm,
    output logic [INSTR_ADDR_WIDTH-1:0] addr,
    output logic [STEP*8-1:0]           data,
    output logic                        cpu_halt,
    output logic                        busy,
    output logic                        done
);

    localparam int AW = INSTR_ADDR_WIDTH;
    localparam int DW = STEP * 8;
    localparam int IW = idx_width(STEP);

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   REM_ONE  = (AW + 1)'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(STEP - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic [DW-1:0] word_q, word_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        if (abort) begin
            // Drop any partially assembled word.
            state_d    = S_IDLE;
            byte_idx_d = '0;
            word_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_COLLECT;
                            cur_addr_d  = base_addr;
                            remaining_d = word_count;
                            byte_idx_d  = '0;
                            word_d      = '0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (byte_valid) begin
                        for (int k = 0; k < STEP; k++) begin
                            if (byte_idx_q == IW'(k)) begin
                                word_d[8*k +: 8] = byte_data;
                            end
                        end
                        if (byte_idx_q == IDX_LAST) begin
                            state_d    = S_WRITE;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (remaining_q == REM_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_COLLECT;
                        cur_addr_d  = cur_addr_q + ADDR_ONE;
                        remaining_d = remaining_q - REM_ONE;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign byte_ready = (state_q == S_COLLECT);
    assign pgm        = (state_q == S_WRITE);
    assign addr       = cur_addr_q;
    assign data       = word_q;
    assign cpu_halt   = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader with a word-level memory model
// built from the byte stream, little-endian packing and address wrap.
module tb_prog_loader;

    localparam int AW   = 5;
    localparam int STEP = 4;
    localparam int DW   = STEP * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          abort = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          pgm;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cpu_halt;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [7:0]    src[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            wt[$];
    int            done_cnt = 0;
    int            rdy_cnt = 0;
    int            cyc_n = 0;

    prog_loader #(
        .INSTR_ADDR_WIDTH(AW),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .abort(abort),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .pgm(pgm),
        .addr(addr),
        .data(data),
        .cpu_halt(cpu_halt),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            cyc_n++;
            if (pgm) begin
                wa.push_back(addr);
                wd.push_back(data);
                wt.push_back(cyc_n);
            end
            if (done) done_cnt++;
            if (byte_ready) begin
                rdy_cnt++;
                checks++;
                if (pgm || !cpu_halt || !busy || done) begin
                    errors++;
                    $display("FAIL ready_state: pgm=%b halt=%b busy=%b done=%b, required 0 1 1 0",
                             pgm, cpu_halt, busy, done);
                end
            end
        end
    end

    function automatic logic [DW-1:0] exp_word(input int i);
        longint v = 0;
        for (int k = 0; k < STEP; k++)
            v += longint'(src[i*STEP + k]) * (longint'(1) << (8 * k));
        return DW'(v);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int base, input int i);
        return AW'((base + i) % (1 << AW));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        wt.delete();
        done_cnt = 0;
        rdy_cnt = 0;
    endtask

    task automatic make_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(255)));
    endtask

    task automatic do_start(input int base, input int cnt);
        start = 1'b1;
        base_addr = AW'(base);
        word_count = (AW + 1)'(cnt);
        tick(1);
        start = 1'b0;
    endtask

    task automatic feed(input int nbytes, input int pct, input int stop_at,
                        input bit noisy, output int got);
        int cyc = 0;
        got = 0;
        while (got < nbytes && cyc < 2000) begin
            byte_valid = ($urandom_range(99) < pct);
            byte_data = src[got];
            if (noisy) begin
                start = 1'($urandom_range(1));
                base_addr = AW'($urandom_range(31));
                word_count = (AW + 1)'($urandom_range(3));
            end
            @(negedge clk);
            if (byte_valid && byte_ready) got++;
            tick(1);
            cyc++;
            if (got == stop_at) break;
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        byte_valid = 1'b1;
        start = 1'b1;
        word_count = (AW + 1)'(3);
        tick(3);
        checks++;
        if ({byte_ready, pgm, cpu_halt, busy, done, addr, data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b pgm=%b halt=%b busy=%b done=%b addr=%h data=%h, required all 0",
                     byte_ready, pgm, cpu_halt, busy, done, addr, data);
        end
        byte_valid = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int got;
        bit ok;
        logic [7:0] b[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_logs();
        src.delete();
        foreach (b[i]) src.push_back(b[i]);
        do_start(16, 2);
        feed(8, 100, -1, 1'b0, got);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout: done not seen, required pulse");
        end
        checks++;
        if (wa.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_counts: writes=%0d done=%0d, required 2 1", wa.size(), done_cnt);
        end else begin
            checks++;
            if (wa[0] !== 5'h10 || wd[0] !== 32'h12345678) begin
                errors++;
                $display("FAIL basic_word0: addr=%h data=%h, required 10 12345678", wa[0], wd[0]);
            end
            checks++;
            if (wa[1] !== 5'h11 || wd[1] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL basic_word1: addr=%h data=%h, required 11 deadbeef", wa[1], wd[1]);
            end
            checks++;
            if (wt[1] - wt[0] != STEP + 1) begin
                errors++;
                $display("FAIL basic_throughput: spacing=%0d, required %0d", wt[1] - wt[0], STEP + 1);
            end
        end
        checks++;
        if (cpu_halt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: halt=%b busy=%b, required 0 0", cpu_halt, busy);
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        do_start(5, 0);
        tick(4);
        checks++;
        if (done_cnt != 1 || wa.size() != 0 || rdy_cnt != 0) begin
            errors++;
            $display("FAIL zero_count: done=%0d writes=%0d ready_cycles=%0d, required 1 0 0",
                     done_cnt, wa.size(), rdy_cnt);
        end
    endtask

    task automatic test_wrap();
        int got;
        bit ok;
        clear_logs();
        make_src(2 * STEP);
        do_start(31, 2);
        feed(2 * STEP, 70, -1, 1'b0, got);
        wait_done(ok);
        checks++;
        if (!ok || wa.size() != 2) begin
            errors++;
            $display("FAIL wrap_counts: done=%0d writes=%0d, required 1 2", done_cnt, wa.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa[i] !== exp_addr(31, i) || wd[i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL wrap_word%0d: addr=%h data=%h, required %h %h",
                             i, wa[i], wd[i], exp_addr(31, i), exp_word(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int got, base, cnt, pct;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            base = $urandom_range(31);
            cnt = (it == 0) ? 1 : $urandom_range(1, 3);
            pct = (it == 0) ? 40 : (it == 4) ? 100 : $urandom_range(20, 100);
            clear_logs();
            make_src(cnt * STEP);
            do_start(base, cnt);
            feed(cnt * STEP, pct, -1, 1'b1, got);
            wait_done(ok);
            checks++;
            if (!ok || done_cnt != 1 || wa.size() != cnt) begin
                errors++;
                $display("FAIL b2b%0d_counts: done=%0d writes=%0d, required 1 %0d",
                         it, done_cnt, wa.size(), cnt);
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    checks++;
                    if (wa[i] !== exp_addr(base, i) || wd[i] !== exp_word(i)) begin
                        errors++;
                        $display("FAIL b2b%0d_word%0d: addr=%h data=%h, required %h %h",
                                 it, i, wa[i], wd[i], exp_addr(base, i), exp_word(i));
                    end
                    if (pct == 100 && i > 0) begin
                        checks++;
                        if (wt[i] - wt[i-1] != STEP + 1) begin
                            errors++;
                            $display("FAIL b2b%0d_rate: spacing=%0d, required %0d",
                                     it, wt[i] - wt[i-1], STEP + 1);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        int got;
        bit ok;
        clear_logs();
        make_src(2 * STEP);
        do_start(3, 2);
        feed(2 * STEP, 100, 2, 1'b0, got);
        abort = 1'b1;
        byte_valid = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || cpu_halt !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b halt=%b ready=%b, required 0 0 0",
                     busy, cpu_halt, byte_ready);
        end
        tick(5);
        byte_valid = 1'b0;
        checks++;
        if (wa.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL abort_quiet: writes=%0d done=%0d, required 0 0", wa.size(), done_cnt);
        end
        clear_logs();
        make_src(STEP);
        do_start(7, 1);
        feed(STEP, 60, -1, 1'b0, got);
        wait_done(ok);
        checks++;
        if (!ok || wa.size() != 1 || wa[0] !== 5'd7 || wd[0] !== exp_word(0)) begin
            errors++;
            $display("FAIL abort_reload: writes=%0d addr=%h data=%h, required 1 07 %h",
                     wa.size(), (wa.size() > 0) ? wa[0] : '0, (wd.size() > 0) ? wd[0] : '0,
                     exp_word(0));
        end
    endtask

    task automatic test_reset_mid();
        int got;
        clear_logs();
        make_src(5 * STEP);
        do_start(20, 5);
        feed(5 * STEP, 100, 3 * STEP, 1'b0, got);
        checks++;
        if (pgm !== 1'b1 || addr !== 5'd22) begin
            errors++;
            $display("FAIL rstmid_in_write: pgm=%b addr=%h, required 1 16", pgm, addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, pgm, cpu_halt, busy, done, addr, data} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: rdy=%b pgm=%b halt=%b busy=%b done=%b addr=%h data=%h, required all 0",
                     byte_ready, pgm, cpu_halt, busy, done, addr, data);
        end
        tick(2);
        rst = 1'b0;
        tick(5);
        checks++;
        if (wa.size() != 2 || done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_counts: writes=%0d done=%0d, required 2 0", wa.size(), done_cnt);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa[i] !== exp_addr(20, i) || wd[i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL rstmid_word%0d: addr=%h data=%h, required %h %h",
                             i, wa[i], wd[i], exp_addr(20, i), exp_word(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
